// File: rtl/psys_pkg.sv
// Shared constants for the 1536-bit inter-switch datapath. The same package
// is used by the inter-switch and by the 1536->128/256 width converters.
package psys_pkg;

    localparam int IN_W  = 128;          // input beat width
    localparam int RATIO = 12;           // beats per packed word
    localparam int OUT_W = IN_W * RATIO; // packed word width (1536)
    localparam int CNT_W = 4;            // lane counter width, holds 0..RATIO

    // Number of lanes filled once a beat lands in lane 'lane'
    function automatic logic [CNT_W-1:0] lanes_used(input logic [CNT_W-1:0] lane);
        return lane + CNT_W'(1);
    endfunction

endpackage

// File: rtl/in128_pack_1536.sv
// Upstream packer: gathers 128-bit AXI-Stream beats into 1536-bit words.
// A packet that ends on tlast before 12 beats is zero-padded to a full word.
// All m_axis outputs come straight from registers.
//
// Handshake: on both sides a transfer happens on a rising clk edge where
// tvalid and tready are both 1. The producer holds data/last/user stable
// while valid is 1 and ready is 0. s_axis_tready only opens when the output
// register is empty or is being drained on the same edge, so a beat is never
// taken while an unconsumed word is held.
module in128_pack_1536
    import psys_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic [CNT_W-1:0] m_axis_tuser,
    input  logic             m_axis_tready,
    output logic [31:0]      word_count
);

    logic [CNT_W-1:0] cnt;        // lane the next accepted beat lands in
    logic             accept;     // input beat handshake this edge
    logic             out_hs;     // output word handshake this edge
    logic             last_lane;  // current lane is the top lane
    logic             complete;   // this edge finishes a word
    logic [OUT_W-1:0] word_next;  // accumulator with the current beat merged in

    assign s_axis_tready = ~rst & (~m_axis_tvalid | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign out_hs        = m_axis_tvalid & m_axis_tready;
    assign last_lane     = (cnt == CNT_W'(RATIO - 1));
    assign complete      = accept & (last_lane | s_axis_tlast);

    // Lane counter: advances per accepted beat, restarts at lane 0 on word completion
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (complete) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Per-lane accumulator. Lanes are cleared whenever a word leaves, so lanes
    // above the last written one are always zero and never carry old data.
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        logic            lane_sel;
        logic [IN_W-1:0] lane_q;

        assign lane_sel = (cnt == CNT_W'(k));

        // Capture the beat into this lane when it is the active lane
        always_ff @(posedge clk) begin
            if (rst || complete) begin
                lane_q <= '0;
            end else if (accept && lane_sel) begin
                lane_q <= s_axis_tdata;
            end
        end

        // The completing beat has not reached its lane register yet, so merge it here
        assign word_next[k*IN_W +: IN_W] = lane_sel ? s_axis_tdata : lane_q;
    end

    // Output register: load on completion, drop valid on handshake, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            m_axis_tdata  <= '0;
        end else if (complete) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tuser  <= lanes_used(cnt);
            m_axis_tdata  <= word_next;
        end else if (out_hs) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Count words handed to the downstream port; wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
        end else if (out_hs) begin
            word_count <= word_count + 32'd1;
        end
    end

endmodule
